// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider covering div/divu/mod/modu through a runtime
// signed/unsigned mode, with defined divide-by-zero results and a flush cancel.
module iter_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the payload is held stable while valid & ~ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_raw_dvd;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remo;
    logic               r_dbz;

    logic               w_accept;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_bit;

    assign w_accept  = in_valid & (r_state == S_IDLE) & ~flush;
    assign w_dvd_mag = (in_signed & dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = (in_signed & divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    // One spare bit above the partial remainder lets the trial difference carry its sign.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dvs};
    assign w_bit   = ~w_diff[WIDTH+1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid)      w_next_state = S_CALC;
            S_CALC: if (r_cnt == '0)   w_next_state = S_DONE;
            S_DONE: if (out_ready)     w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        in_ready    = (r_state == S_IDLE) & ~flush;
        out_valid   = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_raw_dvd <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_remo    <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg_q   <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r   <= in_signed & dividend[WIDTH-1];
                        r_dz      <= (divisor == '0);
                        r_raw_dvd <= dividend;
                        r_dvd     <= w_dvd_mag;
                        r_dvs     <= w_dvs_mag;
                        r_rem     <= '0;
                        r_cnt     <= CNT_W'(WIDTH);
                    end
                end
                S_CALC: begin
                    if (r_cnt != '0) begin
                        r_rem <= w_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], w_bit};
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_dz) begin
                        r_quot <= '1;
                        r_remo <= r_raw_dvd;
                        r_dbz  <= 1'b1;
                    end else begin
                        // r_dvd now holds the magnitude quotient, r_rem the magnitude remainder.
                        r_quot <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
                        r_remo <= r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
                        r_dbz  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider at WIDTH=32 plus a random WIDTH=8 sweep against
// native integer division.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        resetn;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        in_valid32, in_ready32, in_signed32, flush32, out_valid32, out_ready32, dz32;
    logic [31:0] dividend32, divisor32, quotient32, remainder32;
    logic [1:0]  dbg32;

    logic        in_valid8, in_ready8, in_signed8, flush8, out_valid8, out_ready8, dz8;
    logic [7:0]  dividend8, divisor8, quotient8, remainder8;
    logic [1:0]  dbg8;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(32)) u_div32 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_signed(in_signed32), .dividend(dividend32), .divisor(divisor32), .flush(flush32),
        .out_valid(out_valid32), .out_ready(out_ready32), .quotient(quotient32),
        .remainder(remainder32), .div_by_zero(dz32), .o_dbg_state(dbg32)
    );

    iter_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_signed(in_signed8), .dividend(dividend8), .divisor(divisor8), .flush(flush8),
        .out_valid(out_valid8), .out_ready(out_ready8), .quotient(quotient8),
        .remainder(remainder8), .div_by_zero(dz8), .o_dbg_state(dbg8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents operands at a negedge, lets the next posedge accept them, then scrambles them.
    task automatic start32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        in_valid32  = 1'b1;
        in_signed32 = sgn;
        dividend32  = a;
        divisor32   = b;
        #1 check("in_ready_pre_accept32", {63'd0, in_ready32}, 64'd1);
        tick();
        in_valid32 = 1'b0;
        dividend32 = $urandom;
        divisor32  = $urandom;
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!out_valid32 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz);
        int lat;
        out_ready32 = 1'b1;
        start32(sgn, a, b);
        wait32(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_q"}, {32'd0, quotient32}, {32'd0, eq});
        check({tag, "_r"}, {32'd0, remainder32}, {32'd0, er});
        check({tag, "_dz"}, {63'd0, dz32}, {63'd0, edz});
        check({tag, "_in_ready_done"}, {63'd0, in_ready32}, 64'd0);
        tick();
        check({tag, "_out_valid_after"}, {63'd0, out_valid32}, 64'd0);
        check({tag, "_in_ready_after"}, {63'd0, in_ready32}, 64'd1);
    endtask

    task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        int lat;
        int sa, sb, qi, ri;
        logic [7:0] eq, er;
        logic edz;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1;
        end else begin
            sa = sgn ? int'($signed(a)) : int'(a);
            sb = sgn ? int'($signed(b)) : int'(b);
            qi = sa / sb;
            ri = sa % sb;
            eq = qi[7:0]; er = ri[7:0]; edz = 1'b0;
        end
        in_valid8 = 1'b1; in_signed8 = sgn; dividend8 = a; divisor8 = b;
        tick();
        in_valid8 = 1'b0; dividend8 = 8'($urandom); divisor8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            tick();
            lat++;
        end
        check("w8_lat", 64'(lat), 64'd9);
        check("w8_q", {56'd0, quotient8}, {56'd0, eq});
        check("w8_r", {56'd0, remainder8}, {56'd0, er});
        check("w8_dz", {63'd0, dz8}, {63'd0, edz});
        tick();
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        logic rs;
        resetn = 1'b0;
        in_valid32 = 0; in_signed32 = 0; dividend32 = 0; divisor32 = 0; flush32 = 0; out_ready32 = 1;
        in_valid8 = 0; in_signed8 = 0; dividend8 = 0; divisor8 = 0; flush8 = 0; out_ready8 = 1;
        #1;
        check("rst_in_ready", {63'd0, in_ready32}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_q", {32'd0, quotient32}, 64'd0);
        check("rst_r", {32'd0, remainder32}, 64'd0);
        check("rst_dz", {63'd0, dz32}, 64'd0);
        check("rst_state", {62'd0, dbg32}, 64'd0);
        check("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        op32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        op32("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        op32("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        op32("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0);
        op32("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
        op32("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        op32("s_dz", 1'b1, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1);
        op32("u_dz", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1);
        op32("s_neg_dz", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);

        // Backpressure: result parked in DONE for 10 cycles.
        out_ready32 = 1'b0;
        start32(1'b0, 32'd1000, 32'd9);
        wait32(lat);
        check("bp_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", {63'd0, out_valid32}, 64'd1);
            check("bp_q", {32'd0, quotient32}, 64'd111);
            check("bp_r", {32'd0, remainder32}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready32}, 64'd0);
        end
        out_ready32 = 1'b1;
        tick();
        check("bp_released", {63'd0, out_valid32}, 64'd0);
        check("bp_in_ready_after", {63'd0, in_ready32}, 64'd1);

        // Flush at CALC step 5.
        start32(1'b0, 32'hFFFF, 32'd3);
        repeat (4) tick();
        flush32 = 1'b1;
        #1 check("flush_in_ready_low", {63'd0, in_ready32}, 64'd0);
        tick();
        flush32 = 1'b0;
        #1 check("flush_idle", {62'd0, dbg32}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready32}, 64'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid32) lat++;
        end
        check("flush_no_out_valid", 64'(lat), 64'd0);
        op32("after_flush_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Flush while offering operands in IDLE: not accepted.
        in_valid32 = 1'b1; dividend32 = 32'd50; divisor32 = 32'd5; flush32 = 1'b1;
        #1 check("flush_idle_in_ready", {63'd0, in_ready32}, 64'd0);
        tick();
        in_valid32 = 1'b0; flush32 = 1'b0;
        #1 check("flush_idle_not_taken", {62'd0, dbg32}, 64'd0);

        // Asynchronous reset in the middle of CALC.
        start32(1'b0, 32'd77, 32'd5);
        repeat (10) tick();
        #3 resetn = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready32}, 64'd1);
        check("arst_q", {32'd0, quotient32}, 64'd0);
        check("arst_r", {32'd0, remainder32}, 64'd0);
        check("arst_dz", {63'd0, dz32}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        op32("after_rst", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);

        // WIDTH=8 sweep: boundaries first, then random operands.
        op8(1'b1, 8'h80, 8'hFF);
        op8(1'b1, 8'h80, 8'h00);
        op8(1'b0, 8'hFF, 8'h01);
        op8(1'b1, 8'hF9, 8'h02);
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op8(rs, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
